id_decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage. It takes fetched instruction/PC pairs over a valid/ready handshake and splits out the MIPS fields. It also produces an extended immediate, branch/jump targets and a one-hot instruction class. Results go to the execute stage through a two-entry skid buffer, so full throughput is kept under backpressure. Sits between fetch (IF) and execute (EX); flushed by the branch/jump resolution logic.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/id_field_decode.sv | 80 ++++++++
 rtl/id_decode_stage.sv | 135 +++++++++++++
 tb/tb_id_decode_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS32 decode constants: opcodes, instruction-class bits
// and the width of one decoded entry as carried between stages.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam int IC_W      = 6;
  localparam int IC_IALU   = 0;
  localparam int IC_BRANCH = 1;
  localparam int IC_STORE  = 2;
  localparam int IC_LOAD   = 3;
  localparam int IC_JTYPE  = 4;
  localparam int IC_RTYPE  = 5;

  function automatic int entry_w(
    input int data_w,
    input int reg_aw
  );
    return 6 + 3 * reg_aw + 5 + 6
         + IC_W + 4 * data_w;
  endfunction

endpackage

// File: rtl/id_field_decode.sv
// Combinational MIPS32 field split, immediate extension,
// branch/jump target generation and one-hot class decode.
module id_field_decode
  import mips_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int ZERO_EXT_LOGIC = 1
) (
  input  logic [31:0]       instr_i,
  input  logic [DATA_W-1:0] pc_plus4_i,
  output logic [5:0]        opcode_o,
  output logic [REG_AW-1:0] rs_o,
  output logic [REG_AW-1:0] rt_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [4:0]        shamt_o,
  output logic [5:0]        funct_o,
  output logic [DATA_W-1:0] imm_ext_o,
  output logic [DATA_W-1:0] br_tgt_o,
  output logic [DATA_W-1:0] j_tgt_o,
  output logic [IC_W-1:0]   iclass_o
);

  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] zext;
  logic              is_logic;

  assign opcode_o = instr_i[31:26];
  assign rs_o     = REG_AW'(instr_i[25:21]);
  assign rt_o     = REG_AW'(instr_i[20:16]);
  assign rd_o     = REG_AW'(instr_i[15:11]);
  assign shamt_o  = instr_i[10:6];
  assign funct_o  = instr_i[5:0];

  assign sext = {{(DATA_W-16){instr_i[15]}},
                 instr_i[15:0]};
  assign zext = {{(DATA_W-16){1'b0}},
                 instr_i[15:0]};

  assign is_logic = (opcode_o == OP_ANDI)
                  | (opcode_o == OP_ORI)
                  | (opcode_o == OP_XORI);

  always_comb begin
    imm_ext_o = sext;
    if (opcode_o == OP_LUI) begin
      imm_ext_o = zext << 16;
    end else if ((ZERO_EXT_LOGIC != 0)
                 && is_logic) begin
      imm_ext_o = zext;
    end
  end

  // Branch offset is always signed, whatever the opcode
  assign br_tgt_o = pc_plus4_i + (sext << 2);
  assign j_tgt_o  = {pc_plus4_i[DATA_W-1:28],
                     instr_i[25:0], 2'b00};

  always_comb begin
    iclass_o = '0;
    case (opcode_o)
      OP_RTYPE:
        iclass_o[IC_RTYPE] = 1'b1;
      OP_J, OP_JAL:
        iclass_o[IC_JTYPE] = 1'b1;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        iclass_o[IC_LOAD] = 1'b1;
      OP_SB, OP_SH, OP_SW:
        iclass_o[IC_STORE] = 1'b1;
      OP_REGIMM, OP_BEQ, OP_BNE,
      OP_BLEZ, OP_BGTZ:
        iclass_o[IC_BRANCH] = 1'b1;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
        iclass_o[IC_IALU] = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/id_decode_stage.sv
// ID stage: decode up front, then a main/skid register pair so
// the stage streams at full rate under downstream backpressure.
module id_decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 5,
  parameter int ZERO_EXT_LOGIC = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_pc_plus4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [REG_AW-1:0] rs,
  output logic [REG_AW-1:0] rt,
  output logic [REG_AW-1:0] rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] jump_target,
  output logic [IC_W-1:0]   iclass,
  output logic [DATA_W-1:0] out_pc_plus4
);

  localparam int EW = entry_w(DATA_W, REG_AW);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [4:0]        shamt;
    logic [5:0]        funct;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] br_tgt;
    logic [DATA_W-1:0] j_tgt;
    logic [IC_W-1:0]   iclass;
    logic [DATA_W-1:0] pc_plus4;
  } entry_t;

  entry_t            dec;
  entry_t            mo;
  logic [EW-1:0]     dec_bus;
  logic [EW-1:0]     main_q, main_d;
  logic [EW-1:0]     skid_q, skid_d;
  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic              accept;

  id_field_decode #(
    .DATA_W         (DATA_W),
    .REG_AW         (REG_AW),
    .ZERO_EXT_LOGIC (ZERO_EXT_LOGIC)
  ) u_dec (
    .instr_i    (in_instr),
    .pc_plus4_i (in_pc_plus4),
    .opcode_o   (dec.opcode),
    .rs_o       (dec.rs),
    .rt_o       (dec.rt),
    .rd_o       (dec.rd),
    .shamt_o    (dec.shamt),
    .funct_o    (dec.funct),
    .imm_ext_o  (dec.imm_ext),
    .br_tgt_o   (dec.br_tgt),
    .j_tgt_o    (dec.j_tgt),
    .iclass_o   (dec.iclass)
  );

  assign dec.pc_plus4 = in_pc_plus4;
  assign dec_bus      = dec;

  assign in_ready = ~skid_v_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    main_d   = main_q;
    skid_d   = skid_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || out_ready) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (accept) begin
        main_d   = dec_bus;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (accept) begin
      skid_d   = dec_bus;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

  assign mo            = main_q;
  assign out_valid     = main_v_q;
  assign opcode        = mo.opcode;
  assign rs            = mo.rs;
  assign rt            = mo.rt;
  assign rd            = mo.rd;
  assign shamt         = mo.shamt;
  assign funct         = mo.funct;
  assign imm_ext       = mo.imm_ext;
  assign branch_target = mo.br_tgt;
  assign jump_target   = mo.j_tgt;
  assign iclass        = mo.iclass;
  assign out_pc_plus4  = mo.pc_plus4;

endmodule

// File: tb/tb_id_decode_stage.sv
// Bench for id_decode_stage: directed cases then random traffic,
// checked against a queue-based model of the decode stage.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc_plus4;
  logic        out_valid, out_ready;
  logic [5:0]  opcode, funct, iclass;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, branch_target;
  logic [31:0] jump_target, out_pc_plus4;

  always #5 clk = ~clk;

  id_decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc_plus4   (in_pc_plus4),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .shamt         (shamt),
    .funct         (funct),
    .imm_ext       (imm_ext),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .iclass        (iclass),
    .out_pc_plus4  (out_pc_plus4)
  );

  typedef struct {
    logic [37:0] f;
    logic [31:0] imm;
    logic [31:0] bt;
    logic [31:0] jt;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errs   = 0;
  bit   zero_exp;

  function automatic exp_t model(
    input logic [31:0] ins,
    input logic [31:0] pc
  );
    exp_t e;
    int unsigned op, imm16, sx;
    logic [5:0] cls;
    op    = ins >> 26;
    imm16 = ins & 32'hFFFF;
    sx    = (imm16 >= 32768)
          ? imm16 + 32'hFFFF0000 : imm16;
    if (op == 15)
      e.imm = imm16 * 65536;
    else if (op >= 12 && op <= 14)
      e.imm = imm16;
    else
      e.imm = sx;
    e.bt = pc + sx * 4;
    e.jt = (pc & 32'hF0000000)
         | ((ins & 32'h03FFFFFF) * 4);
    e.pc = pc;
    if (op == 0) cls = 6'b100000;
    else if (op == 2 || op == 3) cls = 6'b010000;
    else if (op inside {32, 33, 35, 36, 37})
      cls = 6'b001000;
    else if (op inside {40, 41, 43})
      cls = 6'b000100;
    else if (op == 1 || (op >= 4 && op <= 7))
      cls = 6'b000010;
    else if (op >= 8 && op <= 15)
      cls = 6'b000001;
    else cls = 6'b000000;
    e.f = {ins[31:6], ins[5:0], cls};
    return e;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [37:0] f;
    f = {opcode, rs, rt, rd, shamt, funct, iclass};
    chk("out_valid", 64'(out_valid),
        64'(q.size() > 0));
    chk("in_ready", 64'(in_ready),
        64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("fields", 64'(f), 64'(q[0].f));
      chk("imm_ext", 64'(imm_ext), 64'(q[0].imm));
      chk("br_tgt", 64'(branch_target),
          64'(q[0].bt));
      chk("j_tgt", 64'(jump_target), 64'(q[0].jt));
      chk("pc4", 64'(out_pc_plus4), 64'(q[0].pc));
    end else if (zero_exp) begin
      chk("zero_f", 64'(f), 64'd0);
      chk("zero_d", {imm_ext, branch_target}, 64'd0);
      chk("zero_e", {jump_target, out_pc_plus4},
          64'd0);
    end
  endtask

  task automatic tick(
    input logic        v,
    input logic [31:0] ins,
    input logic [31:0] pc,
    input logic        ordy,
    input logic        fl
  );
    bit acc, pop;
    check_outputs();
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus4 = pc;
    out_ready   = ordy;
    flush       = fl;
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) begin
        q.push_back(model(ins, pc));
        zero_exp = 0;
      end
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] PC0 = 32'h0040_0004;

  initial begin
    logic [5:0]  ops[12];
    logic [31:0] r, ins;
    ops = '{6'h00, 6'h01, 6'h02, 6'h05, 6'h08,
            6'h0C, 6'h0E, 6'h0F, 6'h23, 6'h2B,
            6'h3F, 6'h1A};
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc_plus4 = '0;
    zero_exp = 1;
    @(negedge clk);
    check_outputs();
    @(negedge clk);
    reset = 1'b0;
    tick(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
    tick(0, 0, 0, 1, 0);

    tick(1, 32'h0022_1820, PC0, 1, 0);
    chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_rs_rt_rd", {rs, rt, rd},
        {5'd1, 5'd2, 5'd3});
    chk("add_funct", 64'(funct), 64'h20);
    chk("add_class", 64'(iclass), 64'b100000);
    tick(1, 32'h2008_FFFF, PC0, 1, 0);
    chk("addi_imm", 64'(imm_ext), 64'hFFFF_FFFF);
    tick(1, 32'h3408_FFFF, PC0, 1, 0);
    chk("ori_imm", 64'(imm_ext), 64'h0000_FFFF);
    tick(1, 32'h3C08_1234, PC0, 1, 0);
    chk("lui_imm", 64'(imm_ext), 64'h1234_0000);
    tick(1, 32'h1000_FFFF, PC0, 1, 0);
    chk("beq_tgt", 64'(branch_target),
        64'h0040_0000);
    chk("beq_class", 64'(iclass), 64'b000010);
    tick(1, 32'h0810_0000, PC0, 1, 0);
    chk("j_tgt", 64'(jump_target), 64'h0040_0000);
    tick(1, 32'hFC00_0000, 32'hFFFF_FFFC, 1, 0);
    chk("unk_class", 64'(iclass), 64'd0);
    tick(0, 0, 0, 1, 0);

    tick(1, 32'h8C01_0004, 32'h100, 0, 0);
    tick(1, 32'hAC02_0008, 32'h104, 0, 0);
    chk("bp_rdy", 64'(in_ready), 64'd0);
    tick(1, 32'h2003_0001, 32'h108, 0, 0);
    tick(1, 32'h2003_0001, 32'h108, 1, 0);
    tick(1, 32'h2003_0001, 32'h108, 1, 0);
    tick(1, 32'h0810_0004, 32'h10C, 1, 0);
    tick(0, 0, 0, 1, 0);
    tick(0, 0, 0, 1, 0);

    tick(1, 32'h8C01_0004, 32'h200, 0, 0);
    tick(1, 32'h8C02_0004, 32'h204, 0, 0);
    tick(1, 32'h8C03_0004, 32'h208, 0, 1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_rdy", 64'(in_ready), 64'd1);
    tick(0, 0, 0, 1, 0);
    tick(1, 32'h2004_0010, 32'h20C, 1, 0);
    tick(0, 0, 0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      r   = $urandom();
      ins = $urandom();
      if (r[1:0] != 2'b00)
        ins[31:26] = ops[r[7:4] % 12];
      tick(r[8] | r[9], ins, $urandom(),
           r[10] | r[11], r[15:12] == 4'h0);
    end

    tick(1, 32'h8C01_0004, 32'h300, 0, 0);
    tick(1, 32'h8C02_0004, 32'h304, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_rdy", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm_ext), 64'd0);
    q.delete();
    zero_exp = 1;
    @(negedge clk);
    reset = 1'b0;
    tick(0, 32'h1234_5678, 32'h40, 1, 0);
    tick(0, 32'h1234_5678, 32'h40, 0, 0);
    tick(1, 32'h2008_0005, 32'h44, 1, 0);
    tick(0, 0, 0, 1, 0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==",
             checks, errs);
    $finish;
  end

endmodule
